issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Unified out-of-order issue queue between rename/dispatch (producer of iq_entry_t) and the functional units (consumers).
- Holds up to IQ_LENGTH dispatched instructions and captures operand values from the writeback broadcast (bypass_entry_t).
- Each cycle it offers one instruction whose operands are both ready to the execute stage.
- Sits directly downstream of dispatch and upstream of the ALU/MEM/MUL/DIV/FPU issue mux.

Parameters:
- DEPTH, IQ_LENGTH (8), number of entries.
- IDX_W, IQ_IDX_W (3), slot index width; derived, not overridden.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  mispredict flush; invalidates all entries.
- dispatch_valid  in  1  dispatch_entry is presented.
- dispatch_entry  in  $bits(iq_entry_t)  incoming instruction.
- dispatch_ready  out  1  queue can accept this cycle.
- wb_bus  in  $bits(bypass_entry_t)  writeback broadcast; .valid, .phys_rd, .result.
- issue_valid  out  1  issue_entry holds a ready instruction.
- issue_entry  out  $bits(iq_entry_t)  selected instruction, rs1/rs2 values filled.
- issue_ready  in  1  execute accepts issue_entry.
- occupancy  out  IDX_W+1  number of valid entries.

Behaviour:
- Reset (rst=1 at posedge):
  - All entry valid bits cleared, occupancy=0.
  - Outputs read dispatch_ready=1, issue_valid=0, issue_entry=0.
  - Reset mid-operation discards all entries, with no issue in that cycle.
- Storage: DEPTH registered iq_entry_t slots. The .valid field marks occupancy.
- dispatch_ready = (occupancy != DEPTH). It depends on registered state only, not on same-cycle issue.
- Dispatch: on dispatch_valid && dispatch_ready, the entry is written to the lowest-index free slot with valid=1. dispatch_valid while not ready is ignored, and the producer holds.
- Wakeup: when wb_bus.valid is high, every valid entry compares phys_rs1/phys_rs2 against wb_bus.phys_rd.
  - On a match with rsX_ready=0, the entry sets rsX_ready=1 and rsX_value=wb_bus.result.
  - Entries already ready are untouched.
- Dispatch+wakeup in the same cycle: the incoming entry is also compared. A match is written ready, with the value taken from wb_bus.
- Select (combinational from registered state): issue_valid=1 if any valid entry has rs1_ready && rs2_ready. issue_entry is the lowest-index such entry.
- Issue latency: an entry woken in cycle N is issuable in cycle N+1. A freshly dispatched, fully ready entry is also issuable in cycle N+1.
- Issue handshake: on issue_valid && issue_ready, the selected slot is cleared at the clock edge. issue_entry must stay stable while issue_valid=1 and issue_ready=0, unless a lower-index entry becomes ready. Execute must tolerate that change.
- Simultaneous dispatch and issue when full: dispatch is refused. The freed slot is usable next cycle.
- occupancy update: next = occupancy + dispatch_accept - issue_accept. It never wraps.
- flush: all valid bits cleared at the edge and occupancy=0. Same-cycle dispatch and wakeup are discarded. issue_valid may still be high in the flush cycle; execute must ignore it on flush.
- Precedence: rst > flush > dispatch/wakeup/issue.

Optional Feature:
- Macro: IQ_AGE_SELECT_EN.
- Defined:
  - Each entry carries an age counter of IDX_W bits.
  - On dispatch the new entry's age is 0, and all other valid entries increment, saturating at DEPTH-1.
  - Select picks the ready entry with the greatest age; ties go to the lowest index.
- Undefined: no age storage; plain lowest-index select as above.

Decomposition:
- iq_entry_t, bypass_entry_t, IQ_LENGTH and IQ_IDX_W stay in general_defines. Add fu-type encoding constants (FU_ALU=0, FU_MEM=1, FU_MUL=2, FU_DIV=3, FU_FPU=4) there.
- One natural sub-module, iq_select: a priority/age picker taking ready and age vectors and returning a one-hot grant plus a valid flag.

Test Plan:
- Reset, then dispatch one entry (phys_rs1=5, phys_rs2=6, both ready, values 10/20) → issue_valid=1 the next cycle with values 10/20; with issue_ready=1, occupancy returns to 0.
- Dispatch entry waiting on phys 9, then wb_bus {valid=1, phys_rd=9, result=32'hDEAD} → rs1_value=32'hDEAD and issuable the cycle after the wakeup.
- Dispatch entry with phys_rs2=12 unready in the same cycle as wb_bus phys_rd=12, result=7 → stored ready with rs2_value=7 and issued next cycle.
- Fill 8 entries, none ready → dispatch_ready=0 and a 9th dispatch is ignored. Wake slot 3, issue it → dispatch_ready=1 the following cycle; the next dispatch lands in slot 3.
- Fill 5 entries, assert flush together with dispatch_valid → occupancy=0 and issue_valid=0 next cycle; the dispatched entry is not retained.
- With IQ_AGE_SELECT_EN: dispatch A into slot 0 then B into slot 1, then with slot 0 issued dispatch C into slot 0. Wake B and C together → B issues first; without the macro, C (slot 0) issues first.

Source files
------------

// File: rtl/general_defines.sv
// ---------------------------------------------------------------------------
// Module      : general_defines (package)
// Description : Shared issue-queue types, sizes, FU encodings and wakeup helper.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package general_defines;

  localparam int IQ_LENGTH = 8;
  localparam int IQ_IDX_W  = $clog2(IQ_LENGTH);
  localparam int PHYS_W    = 6;
  localparam int XLEN      = 32;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_MEM = 3'd1,
    FU_MUL = 3'd2,
    FU_DIV = 3'd3,
    FU_FPU = 3'd4
  } fu_type_e;

  typedef struct packed {
    logic              valid;
    fu_type_e          fu_type;
    logic [PHYS_W-1:0] phys_rd;
    logic [PHYS_W-1:0] phys_rs1;
    logic              rs1_ready;
    logic [XLEN-1:0]   rs1_value;
    logic [PHYS_W-1:0] phys_rs2;
    logic              rs2_ready;
    logic [XLEN-1:0]   rs2_value;
  } iq_entry_t;

  typedef struct packed {
    logic              valid;
    logic [PHYS_W-1:0] phys_rd;
    logic [XLEN-1:0]   result;
  } bypass_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);
  localparam int BYPASS_W   = $bits(bypass_entry_t);

  // Capture a broadcast result into any still-waiting source operand.
  function automatic iq_entry_t iq_wakeup(input iq_entry_t e, input bypass_entry_t b);
    iq_entry_t r;
    r = e;
    if (b.valid && !e.rs1_ready && (e.phys_rs1 == b.phys_rd)) begin
      r.rs1_ready = 1'b1;
      r.rs1_value = b.result;
    end
    if (b.valid && !e.rs2_ready && (e.phys_rs2 == b.phys_rd)) begin
      r.rs2_ready = 1'b1;
      r.rs2_value = b.result;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/issue_queue_select.sv
// ---------------------------------------------------------------------------
// Module      : iq_select
// Description : Ready-entry picker: lowest index, or oldest when IQ_AGE_SELECT_EN.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module iq_select
  import general_defines::*;
#(
  parameter int DEPTH = IQ_LENGTH
`ifdef IQ_AGE_SELECT_EN
  ,
  parameter int IDX_W = IQ_IDX_W
`endif
) (
  input  logic [DEPTH-1:0]       ready,
`ifdef IQ_AGE_SELECT_EN
  input  logic [DEPTH*IDX_W-1:0] age,
`endif
  output logic [DEPTH-1:0]       grant,
  output logic                   valid
);

  logic w_found;
`ifdef IQ_AGE_SELECT_EN
  logic [IDX_W-1:0] w_best;
`endif

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    valid   = |ready;
`ifdef IQ_AGE_SELECT_EN
    w_best  = '0;
    // Strict greater-than keeps the lowest index on equal ages.
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!w_found || (age[i*IDX_W +: IDX_W] > w_best))) begin
        w_found  = 1'b1;
        w_best   = age[i*IDX_W +: IDX_W];
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
`else
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !w_found) begin
        w_found  = 1'b1;
        grant[i] = 1'b1;
      end
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/issue_queue.sv
// ---------------------------------------------------------------------------
// Module      : issue_queue
// Description : Unified OoO issue queue with writeback wakeup and one-per-cycle
//               select. Optional age-based select via macro IQ_AGE_SELECT_EN.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module issue_queue
  import general_defines::*;
#(
  parameter  int DEPTH = IQ_LENGTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  dispatch_valid,
  input  logic [IQ_ENTRY_W-1:0] dispatch_entry,
  output logic                  dispatch_ready,
  input  logic [BYPASS_W-1:0]   wb_bus,
  output logic                  issue_valid,
  output logic [IQ_ENTRY_W-1:0] issue_entry,
  input  logic                  issue_ready,
  output logic [IDX_W:0]        occupancy
);

  localparam logic [IDX_W:0] c_depth = (IDX_W+1)'(DEPTH);

  iq_entry_t       r_entries [DEPTH];
  logic [IDX_W:0]  r_occ;

  bypass_entry_t   w_wb;
  iq_entry_t       w_disp;
  iq_entry_t       w_disp_woken;
  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_free;
  logic [DEPTH-1:0] w_grant;
  logic            w_free_found;
  logic            w_sel_valid;
  logic            w_disp_acc;
  logic            w_issue_acc;

  assign w_wb           = bypass_entry_t'(wb_bus);
  assign dispatch_ready = (r_occ != c_depth);
  assign occupancy      = r_occ;
  assign w_disp_acc     = dispatch_valid && dispatch_ready;
  assign issue_valid    = w_sel_valid;
  assign w_issue_acc    = w_sel_valid && issue_ready;

  always_comb begin
    w_disp       = iq_entry_t'(dispatch_entry);
    w_disp.valid = 1'b1;
    w_disp_woken = iq_wakeup(w_disp, w_wb);
  end

  always_comb begin
    w_ready      = '0;
    w_free       = '0;
    w_free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i] = r_entries[i].valid && r_entries[i].rs1_ready && r_entries[i].rs2_ready;
      if (!r_entries[i].valid && !w_free_found) begin
        w_free[i]    = 1'b1;
        w_free_found = 1'b1;
      end
    end
  end

`ifdef IQ_AGE_SELECT_EN
  localparam logic [IDX_W-1:0] c_age_max = IDX_W'(DEPTH - 1);

  logic [IDX_W-1:0]       r_age [DEPTH];
  logic [DEPTH*IDX_W-1:0] w_age_flat;

  always_comb begin
    w_age_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_age_flat[i*IDX_W +: IDX_W] = r_age[i];
    end
  end

  // Ages only move on an accepted dispatch; the newcomer starts youngest.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else if (w_disp_acc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_free[i]) begin
          r_age[i] <= '0;
        end else if (r_entries[i].valid && (r_age[i] != c_age_max)) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end

  iq_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .ready (w_ready),
    .age   (w_age_flat),
    .grant (w_grant),
    .valid (w_sel_valid)
  );
`else
  iq_select #(
    .DEPTH (DEPTH)
  ) u_select (
    .ready (w_ready),
    .grant (w_grant),
    .valid (w_sel_valid)
  );
`endif

  // Grant is one-hot, so the OR-style mux yields zero when nothing is ready.
  always_comb begin
    issue_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) issue_entry = r_entries[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_occ <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i].valid <= 1'b0;
      r_occ <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_issue_acc && w_grant[i]) begin
          r_entries[i].valid <= 1'b0;
        end else if (w_disp_acc && w_free[i]) begin
          r_entries[i] <= w_disp_woken;
        end else if (r_entries[i].valid) begin
          r_entries[i] <= iq_wakeup(r_entries[i], w_wb);
        end
      end
      r_occ <= r_occ + (IDX_W+1)'(w_disp_acc) - (IDX_W+1)'(w_issue_acc);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_issue_queue.sv
// ---------------------------------------------------------------------------
// Module      : tb_issue_queue
// Description : Scoreboard bench for issue_queue; honours IQ_AGE_SELECT_EN.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_issue_queue;
  import general_defines::*;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic                  dispatch_valid;
  logic [IQ_ENTRY_W-1:0] dispatch_entry;
  logic                  dispatch_ready;
  bypass_entry_t         wb;
  logic                  issue_valid;
  logic [IQ_ENTRY_W-1:0] issue_entry;
  logic                  issue_ready;
  logic [IQ_IDX_W:0]     occupancy;

  int n_vec = 0;
  int n_err = 0;
  iq_entry_t sb[$];

  issue_queue dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .dispatch_valid (dispatch_valid),
    .dispatch_entry (dispatch_entry),
    .dispatch_ready (dispatch_ready),
    .wb_bus         (wb),
    .issue_valid    (issue_valid),
    .issue_entry    (issue_entry),
    .issue_ready    (issue_ready),
    .occupancy      (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic iq_entry_t mk(input logic [5:0] rd, input logic [5:0] s1, input logic r1,
                                   input logic [31:0] v1, input logic [5:0] s2, input logic r2,
                                   input logic [31:0] v2);
    iq_entry_t e;
    e = '0;
    e.fu_type   = FU_ALU;
    e.phys_rd   = rd;
    e.phys_rs1  = s1;
    e.rs1_ready = r1;
    e.rs1_value = v1;
    e.phys_rs2  = s2;
    e.rs2_ready = r2;
    e.rs2_value = v2;
    return e;
  endfunction

  // Inputs are stable here, so a handshake now will be taken at the next edge.
  task automatic step();
    iq_entry_t exp;
    if (issue_valid === 1'b1 && issue_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_issue", issue_entry, '0);
      end else begin
        exp = sb.pop_front();
        chk("issue_entry", issue_entry, exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input iq_entry_t e);
    dispatch_valid = 1'b1;
    dispatch_entry = e;
    step();
    dispatch_valid = 1'b0;
  endtask

  task automatic wake(input logic [5:0] rd, input logic [31:0] val);
    wb = '{valid: 1'b1, phys_rd: rd, result: val};
    step();
    wb = '0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    iq_entry_t e, ea, eb, ec, en, e4;
    rst = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; dispatch_entry = '0;
    wb = '0; issue_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_dispatch_ready", dispatch_ready, 1);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_entry", issue_entry, 0);
    chk("rst_occupancy", occupancy, 0);

    // Ready-on-dispatch entry issues the next cycle.
    issue_ready = 1'b1;
    e = mk(6'd1, 6'd5, 1'b1, 32'd10, 6'd6, 1'b1, 32'd20);
    disp(e);
    e.valid = 1'b1; sb.push_back(e);
    chk("t1_issue_valid", issue_valid, 1);
    chk("t1_occupancy", occupancy, 1);
    step();
    chk("t1_occ_after", occupancy, 0);

    // Wakeup on phys 9.
    issue_ready = 1'b0;
    e = mk(6'd2, 6'd9, 1'b0, 32'd0, 6'd6, 1'b1, 32'd20);
    disp(e);
    chk("t2_wait", issue_valid, 0);
    wake(6'd9, 32'hDEAD);
    e.valid = 1'b1; e.rs1_ready = 1'b1; e.rs1_value = 32'hDEAD; sb.push_back(e);
    chk("t2_woken", issue_valid, 1);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;

    // Dispatch and wakeup in the same cycle.
    e = mk(6'd3, 6'd1, 1'b1, 32'd3, 6'd12, 1'b0, 32'd0);
    wb = '{valid: 1'b1, phys_rd: 6'd12, result: 32'd7};
    disp(e);
    wb = '0;
    e.valid = 1'b1; e.rs2_ready = 1'b1; e.rs2_value = 32'd7; sb.push_back(e);
    chk("t3_issue_valid", issue_valid, 1);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    chk("t3_occ", occupancy, 0);

    // Fill, refuse, free slot 3, refill into slot 3.
    for (int i = 0; i < 8; i++)
      disp(mk(6'(i), 6'(20 + i), 1'b0, 32'd0, 6'(40 + i), 1'b1, 32'(i)));
    chk("t4_full_ready", dispatch_ready, 0);
    chk("t4_full_occ", occupancy, 8);
    disp(mk(6'd9, 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd2));
    chk("t4_ninth_ignored", occupancy, 8);
    chk("t4_none_ready", issue_valid, 0);
    wake(6'd23, 32'h33);
    e = mk(6'd3, 6'd23, 1'b1, 32'h33, 6'd43, 1'b1, 32'd3);
    e.valid = 1'b1; sb.push_back(e);
    chk("t4_slot3_ready", issue_valid, 1);
    en = mk(6'd30, 6'd24, 1'b0, 32'd0, 6'd60, 1'b1, 32'h60);
    issue_ready = 1'b1;
    dispatch_valid = 1'b1; dispatch_entry = en;
    step();
    issue_ready = 1'b0;
    chk("t4_refused_occ", occupancy, 7);
    chk("t4_freed_ready", dispatch_ready, 1);
    step();
    dispatch_valid = 1'b0;
    chk("t4_refill_occ", occupancy, 8);
    wake(6'd24, 32'h44);
    en.valid = 1'b1; en.rs1_ready = 1'b1; en.rs1_value = 32'h44;
    e4 = mk(6'd4, 6'd24, 1'b1, 32'h44, 6'd44, 1'b1, 32'd4);
    e4.valid = 1'b1;
`ifdef IQ_AGE_SELECT_EN
    sb.push_back(e4); sb.push_back(en);
`else
    sb.push_back(en); sb.push_back(e4);
`endif
    issue_ready = 1'b1;
    drain(8);
    issue_ready = 1'b0;
    chk("t4_occ_after", occupancy, 6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_flush_occ", occupancy, 0);

    // Flush together with a dispatch.
    for (int i = 0; i < 5; i++)
      disp(mk(6'(i), 6'(10 + i), 1'b0, 32'd0, 6'd2, 1'b1, 32'd2));
    chk("t5_occ5", occupancy, 5);
    flush = 1'b1;
    disp(mk(6'd7, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd6));
    flush = 1'b0;
    chk("t5_flush_occ", occupancy, 0);
    chk("t5_flush_issue", issue_valid, 0);
    wake(6'd10, 32'd1);
    chk("t5_not_retained", issue_valid, 0);
    chk("t5_occ_still0", occupancy, 0);

    // Age versus index select.
    ea = mk(6'd1, 6'd1, 1'b1, 32'hA1, 6'd2, 1'b1, 32'hA2);
    eb = mk(6'd2, 6'd50, 1'b0, 32'd0, 6'd2, 1'b1, 32'hB2);
    ec = mk(6'd3, 6'd50, 1'b0, 32'd0, 6'd2, 1'b1, 32'hC2);
    disp(ea);
    disp(eb);
    ea.valid = 1'b1; sb.push_back(ea);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    disp(ec);
    chk("t6_occ2", occupancy, 2);
    wake(6'd50, 32'h55);
    eb.valid = 1'b1; eb.rs1_ready = 1'b1; eb.rs1_value = 32'h55;
    ec.valid = 1'b1; ec.rs1_ready = 1'b1; ec.rs1_value = 32'h55;
`ifdef IQ_AGE_SELECT_EN
    sb.push_back(eb); sb.push_back(ec);
`else
    sb.push_back(ec); sb.push_back(eb);
`endif
    issue_ready = 1'b1;
    drain(6);
    issue_ready = 1'b0;
    chk("t6_occ0", occupancy, 0);

    // Reset in the middle of operation.
    disp(mk(6'd5, 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd2));
    chk("t7_pre_rst_valid", issue_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t7_rst_occ", occupancy, 0);
    chk("t7_rst_issue_valid", issue_valid, 0);
    chk("t7_rst_ready", dispatch_ready, 1);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
